// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
//   DEF_SYNC_STAGES     - default synchronizer depth
//   DEF_DEBOUNCE_CYCLES - default stable-cycle count (10 ms at CLK_HZ)
//   CLK_HZ              - nominal board clock
//   ms_to_cycles(ms)    - converts a debounce time in ms to clock cycles
package input_cond_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int CLK_HZ              = 100000000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit input conditioning: synchronizer chain, stable-count debouncer,
// and registered one-cycle edge pulses.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous input level
//   clean      : debounced level
//   rise, fall : one-cycle pulses on the edge clean changes 0->1 / 1->0
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   done;

    assign sync = sync_ff[SYNC_STAGES-1];
    assign done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            cnt     <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (sync == clean) begin
                // Any agreeing cycle restarts qualification.
                cnt <= '0;
            end else if (done) begin
                clean <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions N_CH raw board inputs (switches/buttons) for the downstream gate
// stages. Each channel is independent; no combinational path from raw_in.
//   clk, rst_n : clock, async active-low reset
//   raw_in     : asynchronous input levels
//   clean_out  : debounced levels (drive downstream gate a/b inputs)
//   rise_pulse : one-cycle pulse per channel on clean_out 0->1
//   fall_pulse : one-cycle pulse per channel on clean_out 1->0
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_in[i]),
            .clean (clean_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: a level flips at an edge when the synchronized input seen
// over the last DEBOUNCE_CYCLES edges has disagreed with it every time.
module tb_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw_in = 2'b00;
    logic [1:0] clean_out, rise_pulse, fall_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [1:0] samp[$];
    int         ecnt;
    logic [1:0] clean_m, rise_m, fall_m;

    input_conditioner #(
        .N_CH            (2),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        samp.delete();
        ecnt    = 0;
        clean_m = 2'b00;
        rise_m  = 2'b00;
        fall_m  = 2'b00;
    endtask

    // Drive r, take one rising edge, advance the model, settle 1 time unit.
    task automatic step(input logic [1:0] r);
        int  k;
        bit  ok;
        logic d;
        raw_in = r;
        @(posedge clk);
        samp.push_back(r);
        ecnt++;
        rise_m = 2'b00;
        fall_m = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            ok = 1'b1;
            for (int j = 0; j < DC; j++) begin
                k = ecnt - j;
                d = (k - SS >= 1) ? samp[k-SS-1][ch] : 1'b0;
                if (d == clean_m[ch]) ok = 1'b0;
            end
            if (ok) begin
                clean_m[ch] = ~clean_m[ch];
                rise_m[ch]  = clean_m[ch];
                fall_m[ch]  = ~clean_m[ch];
            end
        end
        #1;
    endtask

    // Reset asserted mid-cycle, released just after an edge.
    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        raw_in = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({clean_out, rise_pulse, fall_pulse} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got %b/%b/%b want 00/00/00", clean_out, rise_pulse, fall_pulse);
        end
        rst_n = 1'b1;
        model_clear();
        for (int e = 1; e <= 7; e++) begin
            step(2'b11);
            n_cmp++;
            if (clean_out !== ((e >= 6) ? 2'b11 : 2'b00) ||
                rise_pulse !== ((e == 6) ? 2'b11 : 2'b00)) begin
                n_bad++;
                $display("FAIL reset_qualify edge %0d: clean=%b rise=%b", e, clean_out, rise_pulse);
            end
        end
        // mid-cycle assertion clears outputs immediately
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (clean_out !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_async: clean=%b want 00", clean_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_clean_step();
        pulse_reset();
        for (int e = 1; e <= 8; e++) begin
            step(2'b01);
            n_cmp++;
            if (clean_out[0] !== (e >= 6) || rise_pulse[0] !== (e == 6) || fall_pulse[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL step_rise edge %0d: clean=%b rise=%b fall=%b", e, clean_out[0], rise_pulse[0], fall_pulse[0]);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            step(2'b00);
            n_cmp++;
            if (clean_out[0] !== (e < 6) || fall_pulse[0] !== (e == 6) || rise_pulse[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL step_fall edge %0d: clean=%b rise=%b fall=%b", e, clean_out[0], rise_pulse[0], fall_pulse[0]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] bounce [12];
        pulse_reset();
        for (int e = 1; e <= 12; e++) begin
            step((e <= 3) ? 2'b10 : 2'b00);
            n_cmp++;
            if (clean_out[1] !== 1'b0 || rise_pulse[1] !== 1'b0 || fall_pulse[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_reject edge %0d: clean=%b rise=%b fall=%b", e, clean_out[1], rise_pulse[1], fall_pulse[1]);
            end
        end
        pulse_reset();
        for (int e = 0; e < 12; e++) bounce[e] = (e == 2) ? 2'b00 : 2'b10;
        for (int e = 1; e <= 12; e++) begin
            step(bounce[e-1]);
            // new level held from edge 4 -> accepted on edge 4+SS+DC-1 = 9
            n_cmp++;
            if (clean_out[1] !== (e >= 9) || rise_pulse[1] !== (e == 9)) begin
                n_bad++;
                $display("FAIL glitch_bounce edge %0d: clean=%b rise=%b want %b/%b", e, clean_out[1], rise_pulse[1], e >= 9, e == 9);
            end
        end
    endtask

    task automatic test_independence();
        pulse_reset();
        repeat (8) step(2'b10);
        n_cmp++;
        if (clean_out !== 2'b10) begin
            n_bad++;
            $display("FAIL indep_setup: clean=%b want 10", clean_out);
        end
        for (int e = 1; e <= 7; e++) begin
            step(2'b01);
            n_cmp++;
            if (clean_out !== ((e >= 6) ? 2'b01 : 2'b10) ||
                rise_pulse !== ((e == 6) ? 2'b01 : 2'b00) ||
                fall_pulse !== ((e == 6) ? 2'b10 : 2'b00)) begin
                n_bad++;
                $display("FAIL indep_swap edge %0d: clean=%b rise=%b fall=%b", e, clean_out, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        pulse_reset();
        repeat (4) step(2'b01);
        pulse_reset();
        for (int e = 1; e <= 7; e++) begin
            step(2'b01);
            n_cmp++;
            if (clean_out[0] !== (e >= 6) || rise_pulse[0] !== (e == 6)) begin
                n_bad++;
                $display("FAIL reset_mid edge %0d: clean=%b rise=%b", e, clean_out[0], rise_pulse[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] lvl;
        int         hold [2];
        pulse_reset();
        lvl = 2'b00;
        hold[0] = 0;
        hold[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 9);
                end
                hold[ch]--;
            end
            step(lvl);
            n_cmp++;
            if (clean_out !== clean_m || rise_pulse !== rise_m || fall_pulse !== fall_m ||
                (rise_pulse & fall_pulse) !== 2'b00) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b/%b/%b want %b/%b/%b", n,
                         clean_out, rise_pulse, fall_pulse, clean_m, rise_m, fall_m);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_step();
        test_glitch();
        test_independence();
        test_reset_mid_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
